// File: rtl/change_dispenser.sv
// Greedy two-denomination change payout: large coin first, one hopper ack per coin.
// Define DISP_STATS_EN to add the total_paid / short_events statistics ports.

module change_dispenser #(
    parameter int AMT_W   = 4,
    parameter int DEN_HI  = 2,
    parameter int CNT_W   = 6,
    parameter int INIT_HI = 20,
    parameter int INIT_LO = 20,
    parameter int ACK_TO  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    output logic             coin_hi,
    output logic             coin_lo,
    input  logic             hop_ack,
    input  logic             refill,
    output logic             done,
    output logic             short,
    output logic             timeout,
    output logic [AMT_W-1:0] rem_amt,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [CNT_W-1:0] lo_cnt,
    output logic             busy
`ifdef DISP_STATS_EN
    ,
    output logic [15:0]      total_paid,
    output logic [7:0]       short_events
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEL  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int WC_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    localparam logic [AMT_W-1:0] DEN_HI_V  = AMT_W'(DEN_HI);
    localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);
    localparam logic [CNT_W-1:0] INIT_HI_V = CNT_W'(INIT_HI);
    localparam logic [CNT_W-1:0] INIT_LO_V = CNT_W'(INIT_LO);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(ACK_TO - 1);
    localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);

    logic [1:0]       state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             sel_hi_q, sel_hi_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             coin_hi_q, coin_hi_d;
    logic             coin_lo_q, coin_lo_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic             timeout_q, timeout_d;
    logic [AMT_W-1:0] rem_amt_q, rem_amt_d;
    logic             fin_entry;
    logic [AMT_W-1:0] ack_units;

    assign ack_units = sel_hi_q ? DEN_HI_V : AMT_ONE;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        sel_hi_d  = sel_hi_q;
        wait_d    = wait_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        coin_hi_d = 1'b0;
        coin_lo_d = 1'b0;
        done_d    = 1'b0;
        short_d   = short_q;
        timeout_d = timeout_q;
        rem_amt_d = rem_amt_q;
        fin_entry = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Refill loads first so a request accepted on the same edge sees full counters.
                if (refill) begin
                    hi_d = INIT_HI_V;
                    lo_d = INIT_LO_V;
                end
                if (req_valid) begin
                    rem_d     = req_amt;
                    short_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_SEL;
                end
            end
            S_SEL: begin
                if (rem_q == '0) begin
                    fin_entry = 1'b1;
                end else if (rem_q >= DEN_HI_V && hi_q != '0) begin
                    coin_hi_d = 1'b1;
                    sel_hi_d  = 1'b1;
                    wait_d    = '0;
                    state_d   = S_WAIT;
                end else if (lo_q != '0) begin
                    coin_lo_d = 1'b1;
                    sel_hi_d  = 1'b0;
                    wait_d    = '0;
                    state_d   = S_WAIT;
                end else begin
                    short_d   = 1'b1;
                    fin_entry = 1'b1;
                end
            end
            S_WAIT: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (hop_ack) begin
                    rem_d = rem_q - ack_units;
                    if (sel_hi_q) begin
                        if (hi_q != '0) hi_d = hi_q - CNT_ONE;
                    end else if (lo_q != '0) begin
                        lo_d = lo_q - CNT_ONE;
                    end
                    state_d = S_SEL;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    short_d   = 1'b1;
                    fin_entry = 1'b1;
                end else begin
                    wait_d = wait_q + WC_ONE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin_entry) begin
            state_d   = S_FIN;
            done_d    = 1'b1;
            rem_amt_d = rem_d;
            if (rem_d != '0) short_d = 1'b1;
        end

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            sel_hi_q    <= 1'b0;
            wait_q      <= '0;
            hi_q        <= INIT_HI_V;
            lo_q        <= INIT_LO_V;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            coin_hi_q   <= 1'b0;
            coin_lo_q   <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            timeout_q   <= 1'b0;
            rem_amt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            sel_hi_q    <= sel_hi_d;
            wait_q      <= wait_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            coin_hi_q   <= coin_hi_d;
            coin_lo_q   <= coin_lo_d;
            done_q      <= done_d;
            short_q     <= short_d;
            timeout_q   <= timeout_d;
            rem_amt_q   <= rem_amt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign coin_hi   = coin_hi_q;
    assign coin_lo   = coin_lo_q;
    assign done      = done_q;
    assign short     = short_q;
    assign timeout   = timeout_q;
    assign rem_amt   = rem_amt_q;
    assign hi_cnt    = hi_q;
    assign lo_cnt    = lo_q;

`ifdef DISP_STATS_EN
    logic [15:0] total_paid_q, total_paid_d;
    logic [7:0]  short_ev_q, short_ev_d;
    logic [16:0] paid_sum;
    logic        coin_acked;

    assign coin_acked = (state_q == S_WAIT) && hop_ack;

    // Both statistics saturate rather than wrap; refill leaves them alone.
    always_comb begin
        paid_sum     = {1'b0, total_paid_q} + 17'(ack_units);
        total_paid_d = total_paid_q;
        short_ev_d   = short_ev_q;
        if (coin_acked) total_paid_d = paid_sum[16] ? 16'hFFFF : paid_sum[15:0];
        if (fin_entry && short_d && short_ev_q != 8'hFF) short_ev_d = short_ev_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_paid_q <= '0;
            short_ev_q   <= '0;
        end else begin
            total_paid_q <= total_paid_d;
            short_ev_q   <= short_ev_d;
        end
    end

    assign total_paid   = total_paid_q;
    assign short_events = short_ev_q;
`endif

endmodule
